// File: rtl/sd_access_arb.sv
// SD card access arbiter: queues one write and one read request and hands them
// to the SD controller in round-robin order. Optional macro: ARB_START_TIMEOUT_EN.
module sd_access_arb #(
    parameter int START_TO = 16,
    parameter int ADDR_W   = 32
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              sd_init_done,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] wr_req_addr,
    input  logic [ADDR_W-1:0] rd_req_addr,
    input  logic              sd_wr_busy,
    input  logic              sd_rd_busy,
    output logic              sd_wr_en,
    output logic              sd_rd_en,
    output logic [ADDR_W-1:0] sd_wr_addr,
    output logic [ADDR_W-1:0] sd_rd_addr,
    output logic              wr_pend,
    output logic              rd_pend,
    output logic              wr_done,
    output logic              rd_done,
    output logic              arb_busy,
    output logic              arb_err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WR_HI = 3'd1,
        WR_LO = 3'd2,
        RD_HI = 3'd3,
        RD_LO = 3'd4
    } state_t;

    // The start timeout counter needs at least one cycle of budget.
    if (START_TO < 1) begin : g_bad_start_to
        $error("START_TO must be at least 1");
    end

    state_t state_q, state_d;

    logic              wr_pend_q, wr_pend_d;
    logic              rd_pend_q, rd_pend_d;
    logic [ADDR_W-1:0] wr_cap_q, wr_cap_d;
    logic [ADDR_W-1:0] rd_cap_q, rd_cap_d;
    logic [ADDR_W-1:0] sd_wr_addr_q, sd_wr_addr_d;
    logic [ADDR_W-1:0] sd_rd_addr_q, sd_rd_addr_d;
    logic              sd_wr_en_q, sd_wr_en_d;
    logic              sd_rd_en_q, sd_rd_en_d;
    logic              wr_done_q, wr_done_d;
    logic              rd_done_q, rd_done_d;
    logic              arb_busy_q, arb_busy_d;
    logic              last_rd_q, last_rd_d;
    logic              wr_busy_q;
    logic              rd_busy_q;

    logic              wr_svc;
    logic              rd_svc;
    logic              wr_acc;
    logic              rd_acc;
    logic              can_gnt;
    logic              gnt_wr;
    logic              gnt_rd;

`ifdef ARB_START_TIMEOUT_EN
    localparam int CNT_W = $clog2(START_TO + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(START_TO - 1);

    logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
    logic             arb_err_q, arb_err_d;
`endif

    // Request acceptance and grant decision.
    always_comb begin
        wr_svc  = (state_q == WR_HI) || (state_q == WR_LO);
        rd_svc  = (state_q == RD_HI) || (state_q == RD_LO);
        wr_acc  = wr_req && !wr_pend_q && !wr_svc;
        rd_acc  = rd_req && !rd_pend_q && !rd_svc;
        can_gnt = (state_q == IDLE) && sd_init_done;
        gnt_wr  = can_gnt && wr_pend_q && (!rd_pend_q || last_rd_q);
        gnt_rd  = can_gnt && rd_pend_q && (!wr_pend_q || !last_rd_q);
    end

    // Next-state and next-output computation for the arbiter FSM.
    always_comb begin
        state_d      = state_q;
        wr_pend_d    = wr_pend_q | wr_acc;
        rd_pend_d    = rd_pend_q | rd_acc;
        wr_cap_d     = wr_acc ? wr_req_addr : wr_cap_q;
        rd_cap_d     = rd_acc ? rd_req_addr : rd_cap_q;
        sd_wr_addr_d = sd_wr_addr_q;
        sd_rd_addr_d = sd_rd_addr_q;
        sd_wr_en_d   = 1'b0;
        sd_rd_en_d   = 1'b0;
        wr_done_d    = 1'b0;
        rd_done_d    = 1'b0;
        last_rd_d    = last_rd_q;
`ifdef ARB_START_TIMEOUT_EN
        to_cnt_d     = to_cnt_q;
        arb_err_d    = 1'b0;
`endif
        unique case (state_q)
            IDLE: begin
                if (gnt_wr) begin
                    sd_wr_en_d   = 1'b1;
                    sd_wr_addr_d = wr_cap_q;
                    wr_pend_d    = 1'b0;
                    last_rd_d    = 1'b0;
                    state_d      = WR_HI;
`ifdef ARB_START_TIMEOUT_EN
                    to_cnt_d     = '0;
`endif
                end else if (gnt_rd) begin
                    sd_rd_en_d   = 1'b1;
                    sd_rd_addr_d = rd_cap_q;
                    rd_pend_d    = 1'b0;
                    last_rd_d    = 1'b1;
                    state_d      = RD_HI;
`ifdef ARB_START_TIMEOUT_EN
                    to_cnt_d     = '0;
`endif
                end
            end
            WR_HI: begin
                if (sd_wr_busy) begin
                    state_d = WR_LO;
`ifdef ARB_START_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    arb_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
`endif
                end
            end
            WR_LO: begin
                if (!sd_wr_busy && wr_busy_q) begin
                    wr_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            RD_HI: begin
                if (sd_rd_busy) begin
                    state_d = RD_LO;
`ifdef ARB_START_TIMEOUT_EN
                end else if (to_cnt_q == TO_LAST) begin
                    arb_err_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    to_cnt_d = to_cnt_q + CNT_W'(1);
`endif
                end
            end
            RD_LO: begin
                if (!sd_rd_busy && rd_busy_q) begin
                    rd_done_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        arb_busy_d = (state_d != IDLE);
    end

    // Arbiter FSM state and registered outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            wr_pend_q    <= 1'b0;
            rd_pend_q    <= 1'b0;
            wr_cap_q     <= '0;
            rd_cap_q     <= '0;
            sd_wr_addr_q <= '0;
            sd_rd_addr_q <= '0;
            sd_wr_en_q   <= 1'b0;
            sd_rd_en_q   <= 1'b0;
            wr_done_q    <= 1'b0;
            rd_done_q    <= 1'b0;
            arb_busy_q   <= 1'b0;
            last_rd_q    <= 1'b1;
        end else begin
            state_q      <= state_d;
            wr_pend_q    <= wr_pend_d;
            rd_pend_q    <= rd_pend_d;
            wr_cap_q     <= wr_cap_d;
            rd_cap_q     <= rd_cap_d;
            sd_wr_addr_q <= sd_wr_addr_d;
            sd_rd_addr_q <= sd_rd_addr_d;
            sd_wr_en_q   <= sd_wr_en_d;
            sd_rd_en_q   <= sd_rd_en_d;
            wr_done_q    <= wr_done_d;
            rd_done_q    <= rd_done_d;
            arb_busy_q   <= arb_busy_d;
            last_rd_q    <= last_rd_d;
        end
    end

    // One-cycle copies of the busy lines for falling-edge detection.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_busy_q <= 1'b0;
            rd_busy_q <= 1'b0;
        end else begin
            wr_busy_q <= sd_wr_busy;
            rd_busy_q <= sd_rd_busy;
        end
    end

`ifdef ARB_START_TIMEOUT_EN
    // Start timeout counter and error pulse.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            to_cnt_q  <= '0;
            arb_err_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            arb_err_q <= arb_err_d;
        end
    end

    assign arb_err = arb_err_q;
`else
    assign arb_err = 1'b0;
`endif

    assign sd_wr_en   = sd_wr_en_q;
    assign sd_rd_en   = sd_rd_en_q;
    assign sd_wr_addr = sd_wr_addr_q;
    assign sd_rd_addr = sd_rd_addr_q;
    assign wr_pend    = wr_pend_q;
    assign rd_pend    = rd_pend_q;
    assign wr_done    = wr_done_q;
    assign rd_done    = rd_done_q;
    assign arb_busy   = arb_busy_q;

endmodule

// File: tb/tb_sd_access_arb.sv
// Self-checking bench for sd_access_arb: table-driven request vectors with a
// grant scoreboard, plus hand sequences for init gating, reset and start timeout.
module tb_sd_access_arb;

    localparam int AW = 32;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          init_done;
    logic          wr_req, rd_req;
    logic [AW-1:0] wr_req_addr, rd_req_addr;
    logic          sd_wr_busy, sd_rd_busy;
    logic          sd_wr_en, sd_rd_en;
    logic [AW-1:0] sd_wr_addr, sd_rd_addr;
    logic          wr_pend, rd_pend, wr_done, rd_done, arb_busy, arb_err;

    sd_access_arb #(.START_TO(TO), .ADDR_W(AW)) dut (
        .sys_clk     (clk),
        .sys_rst     (rst),
        .sd_init_done(init_done),
        .wr_req      (wr_req),
        .rd_req      (rd_req),
        .wr_req_addr (wr_req_addr),
        .rd_req_addr (rd_req_addr),
        .sd_wr_busy  (sd_wr_busy),
        .sd_rd_busy  (sd_rd_busy),
        .sd_wr_en    (sd_wr_en),
        .sd_rd_en    (sd_rd_en),
        .sd_wr_addr  (sd_wr_addr),
        .sd_rd_addr  (sd_rd_addr),
        .wr_pend     (wr_pend),
        .rd_pend     (rd_pend),
        .wr_done     (wr_done),
        .rd_done     (rd_done),
        .arb_busy    (arb_busy),
        .arb_err     (arb_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit            rd;
        logic [AW-1:0] addr;
    } exp_t;

    typedef struct {
        bit            wr;
        bit            rd;
        logic [AW-1:0] waddr;
        logic [AW-1:0] raddr;
        bit            rd_first;
    } vec_t;

    exp_t exp_q[$];
    vec_t vecs[8];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int wr_done_cnt = 0, rd_done_cnt = 0;
    int exp_wr_done = 0, exp_rd_done = 0;
    int err_cnt = 0;
    int en_cyc = 0, wfall = -10, rfall = -10;
    bit prev_wb = 0, prev_rb = 0;

    bit resp_wr_on = 1, resp_rd_on = 1;
    int w_dly = 2, w_len = 3, r_dly = 2, r_len = 3;
    int wcnt = 0, rcnt = 0;

    task automatic check(string name, logic [63:0] act, logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Busy responder: raise busy dly cycles after an enable pulse, for len cycles.
    initial begin
        sd_wr_busy = 0;
        sd_rd_busy = 0;
        forever begin
            @(posedge clk);
            #1;
            if (resp_wr_on) begin
                if (wcnt == 0 && sd_wr_en) wcnt = 1;
                else if (wcnt != 0) wcnt++;
                sd_wr_busy = (wcnt > w_dly) && (wcnt <= w_dly + w_len);
                if (wcnt > w_dly + w_len) wcnt = 0;
            end
            if (resp_rd_on) begin
                if (rcnt == 0 && sd_rd_en) rcnt = 1;
                else if (rcnt != 0) rcnt++;
                sd_rd_busy = (rcnt > r_dly) && (rcnt <= r_dly + r_len);
                if (rcnt > r_dly + r_len) rcnt = 0;
            end
        end
    end

    // Monitor: grant scoreboard, done latency, error latency.
    always @(negedge clk) begin
        if (!rst) begin
            if (sd_wr_en || sd_rd_en) begin
                en_cyc = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant: wr_en=%0b rd_en=%0b expected none",
                             sd_wr_en, sd_rd_en);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("grant_onehot", {sd_wr_en, sd_rd_en}, e.rd ? 2'b01 : 2'b10);
                    check("grant_addr", e.rd ? sd_rd_addr : sd_wr_addr, e.addr);
                end
            end
            if (wr_done) begin
                wr_done_cnt++;
                check("wr_done_lat", cyc - wfall, 1);
            end
            if (rd_done) begin
                rd_done_cnt++;
                check("rd_done_lat", cyc - rfall, 1);
            end
            if (arb_err) begin
                err_cnt++;
`ifdef ARB_START_TIMEOUT_EN
                check("err_lat", cyc - en_cyc, TO);
`endif
            end
        end
        if (prev_wb && !sd_wr_busy) wfall = cyc;
        if (prev_rb && !sd_rd_busy) rfall = cyc;
        prev_wb = sd_wr_busy;
        prev_rb = sd_rd_busy;
    end

    task automatic pulse(bit w, bit r, logic [AW-1:0] wa, logic [AW-1:0] ra);
        @(posedge clk);
        #1;
        wr_req      = w;
        rd_req      = r;
        wr_req_addr = wa;
        rd_req_addr = ra;
        @(posedge clk);
        #1;
        wr_req = 0;
        rd_req = 0;
    endtask

    task automatic wait_quiet(int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!arb_busy && !wr_pend && !rd_pend && !wr_done && !rd_done) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            n_tests++;
            n_fail++;
            $display("FAIL quiet_timeout: arb_busy=%0b still set after %0d cycles",
                     arb_busy, budget);
        end
    endtask

    task automatic wait_wr_busy(int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sd_wr_busy) begin
                ok = 1;
                break;
            end
        end
        check("wr_busy_seen", ok, 1);
    endtask

    task automatic check_all_zero(string tag);
        check({tag, "_flags"},
              {sd_wr_en, sd_rd_en, wr_pend, rd_pend, wr_done, rd_done, arb_busy, arb_err},
              8'h00);
        check({tag, "_wr_addr"}, sd_wr_addr, 0);
        check({tag, "_rd_addr"}, sd_rd_addr, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        vecs[0] = '{1, 1, 32'h100, 32'h200, 0};
        vecs[1] = '{1, 1, 32'h101, 32'h201, 0};
        vecs[2] = '{1, 0, 32'h102, 32'h0,   0};
        vecs[3] = '{1, 1, 32'h103, 32'h203, 1};
        vecs[4] = '{0, 1, 32'h0,   32'h204, 0};
        vecs[5] = '{1, 1, 32'h105, 32'h205, 0};
        vecs[6] = '{1, 0, 32'h106, 32'h0,   0};
        vecs[7] = '{0, 1, 32'h0,   32'h207, 0};

        rst = 1;
        init_done = 1;
        wr_req = 0;
        rd_req = 0;
        wr_req_addr = 0;
        rd_req_addr = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        rst = 0;

        // Table: request patterns with expected grant order.
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].wr && vecs[i].rd) begin
                if (vecs[i].rd_first) begin
                    exp_q.push_back('{1, vecs[i].raddr});
                    exp_q.push_back('{0, vecs[i].waddr});
                end else begin
                    exp_q.push_back('{0, vecs[i].waddr});
                    exp_q.push_back('{1, vecs[i].raddr});
                end
            end else if (vecs[i].wr) begin
                exp_q.push_back('{0, vecs[i].waddr});
            end else begin
                exp_q.push_back('{1, vecs[i].raddr});
            end
            exp_wr_done += int'(vecs[i].wr);
            exp_rd_done += int'(vecs[i].rd);
            pulse(vecs[i].wr, vecs[i].rd, vecs[i].waddr, vecs[i].raddr);
            wait_quiet(200);
            check("vec_sb_empty", exp_q.size(), 0);
        end
        check("vec_wr_dones", wr_done_cnt, exp_wr_done);
        check("vec_rd_dones", rd_done_cnt, exp_rd_done);

        // Long write; second request and init_done drop during WR_LO.
        w_dly = 3;
        w_len = 20;
        exp_q.push_back('{0, 32'h10});
        exp_wr_done++;
        pulse(1, 0, 32'h10, 32'h0);
        wait_wr_busy(20);
        repeat (3) @(posedge clk);
        #1;
        init_done = 0;
        pulse(1, 0, 32'h20, 32'h0);
        check("wr_req_ignored", wr_pend, 0);
        check("wr_lo_busy", arb_busy, 1);
        wait_quiet(100);
        check("wr_addr_hold", sd_wr_addr, 32'h10);
        check("wr_done_init_low", wr_done_cnt, exp_wr_done);
        w_dly = 2;
        w_len = 3;

        // Read held pending while init_done is low.
        exp_q.push_back('{1, 32'h55});
        exp_rd_done++;
        pulse(0, 1, 32'h0, 32'h55);
        repeat (50) @(posedge clk);
        @(negedge clk);
        check("rd_pend_held", {rd_pend, arb_busy, sd_rd_en}, 3'b100);
        @(posedge clk);
        #1;
        init_done = 1;
        @(negedge clk);
        check("rd_en_early", sd_rd_en, 0);
        @(negedge clk);
        check("rd_en_after_init", sd_rd_en, 1);
        wait_quiet(100);

        // Write request in the same cycle as its own done pulse.
        exp_q.push_back('{0, 32'h77});
        exp_q.push_back('{0, 32'h78});
        exp_wr_done += 2;
        pulse(1, 0, 32'h77, 32'h0);
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clk);
            #1;
            if (wr_done) begin
                seen = 1;
                break;
            end
        end
        check("done_seen", seen, 1);
        wr_req = 1;
        wr_req_addr = 32'h78;
        @(posedge clk);
        #1;
        wr_req = 0;
        check("req_on_done", wr_pend, 1);
        wait_quiet(100);
        check("done_pair", wr_done_cnt, exp_wr_done);

        // Reset during WR_LO with a read pending.
        w_len = 10;
        exp_q.push_back('{0, 32'h99});
        pulse(1, 0, 32'h99, 32'h0);
        wait_wr_busy(20);
        pulse(0, 1, 32'h0, 32'h66);
        check("rd_pend_pre_rst", rd_pend, 1);
        @(posedge clk);
        #1;
        rst = 1;
        #1;
        check_all_zero("midrst");
        @(posedge clk);
        #1;
        rst = 0;
        repeat (30) @(posedge clk);
        @(negedge clk);
        check("rst_no_done", wr_done_cnt, exp_wr_done);
        check("rst_idle", {arb_busy, wr_pend, rd_pend}, 3'b000);
        w_len = 3;

        // Start timeout (or indefinite wait) on the read channel.
        resp_rd_on = 0;
        sd_rd_busy = 0;
        exp_q.push_back('{1, 32'hAB});
`ifdef ARB_START_TIMEOUT_EN
        pulse(0, 1, 32'h0, 32'hAB);
        repeat (40) @(posedge clk);
        @(negedge clk);
        check("to_err_cnt", err_cnt, 1);
        check("to_idle", arb_busy, 0);
        check("to_no_done", rd_done_cnt, exp_rd_done);
`else
        pulse(0, 1, 32'h0, 32'hAB);
        repeat (40) @(posedge clk);
        resp_wr_on = 0;
        #1;
        sd_wr_busy = 1;
        repeat (3) @(posedge clk);
        #1;
        sd_wr_busy = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("hi_wait_busy", arb_busy, 1);
        check("hi_no_rd_done", rd_done_cnt, exp_rd_done);
        check("other_busy_ign", wr_done_cnt, exp_wr_done);
        resp_wr_on = 1;
        exp_rd_done++;
        @(posedge clk);
        #1;
        sd_rd_busy = 1;
        repeat (2) @(posedge clk);
        #1;
        sd_rd_busy = 0;
        wait_quiet(50);
        check("err_tied_low", err_cnt, 0);
`endif
        resp_rd_on = 1;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("final_sb_empty", exp_q.size(), 0);
        check("final_wr_dones", wr_done_cnt, exp_wr_done);
        check("final_rd_dones", rd_done_cnt, exp_rd_done);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
